nn_mem_arbiter: RTL and testbench

- Arbitrates the single physical port of the shared 2048 x 16 block memory among three requesters:
  - instruction fetch: single-word read;
  - data load/store: single-word read or write;
  - node-vector fetch: 16-word burst read feeding the neuron array.
- Sits between the sequencer/datapath and the memory macro.
- Grants one access per cycle using round-robin priority. A node burst holds the port for its whole length.

---
 rtl/nn_mem_arbiter_pkg.sv | 25 ++
 rtl/nn_mem_arbiter_if.sv | 62 ++++++
 rtl/nn_mem_arbiter_rr_arbiter3.sv | 59 +++++
 rtl/nn_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_nn_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_mem_arbiter_pkg.sv
// nn_mem_arb_pkg
// Shared types and sizing constants for the block-memory arbiter.
//   req_id_t     : requester identity, also the bit position in grant/request vectors
//   arb_state_t  : arbiter FSM states
//   MEM_DATA_W   : memory word width
//   MEM_ADDR_W   : memory word address width
//   NODE_BURST_LEN : words per node-vector burst (power of two)
package nn_mem_arb_pkg;

    localparam int MEM_DATA_W     = 16;
    localparam int MEM_ADDR_W     = 11;
    localparam int NODE_BURST_LEN = 16;

    typedef enum logic [1:0] {
        REQ_INSTR = 2'd0,
        REQ_DATA  = 2'd1,
        REQ_NODE  = 2'd2
    } req_id_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/nn_mem_arbiter_if.sv
// nn_mem_arbiter_if
// Bundles the three requester ports and the memory macro port of the arbiter.
//   master modport : requester/memory side (drives requests and mem_rdata)
//   slave modport  : arbiter side (drives grants, read returns and mem_* controls)
interface nn_mem_arbiter_if
    import nn_mem_arb_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) ();

    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_gnt;
    logic              instr_rvalid;
    logic [DATA_W-1:0] instr_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              node_req;
    logic [ADDR_W-1:0] node_addr;
    logic              node_gnt;
    logic              node_rvalid;
    logic [DATA_W-1:0] node_rdata;
    logic [3:0]        node_idx;
    logic              node_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        output node_req, node_addr,
        input  node_gnt, node_rvalid, node_rdata, node_idx, node_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        input  node_req, node_addr,
        output node_gnt, node_rvalid, node_rdata, node_idx, node_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/nn_mem_arbiter_rr_arbiter3.sv
// rr_arbiter3
// Three-way rotating-priority arbiter. The most recently granted requester
// drops to lowest priority while the other two keep their relative order.
//   clk, rst : clock, asynchronous active-low reset (order instr > data > node)
//   req      : request vector, bit index = req_id_t
//   update   : allow the priority order to change on this cycle's grant
//   gnt      : one-hot grant, combinational from req and the stored order
module rr_arbiter3
    import nn_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       update,
    output logic [2:0] gnt
);

    // Pairwise precedence bits: a bit set means the first-named requester
    // currently outranks the second. Three bits fully describe the order.
    logic instrOverData;
    logic instrOverNode;
    logic dataOverNode;

    // A requester wins when it beats every other requester that is asking.
    always_comb begin
        gnt            = '0;
        gnt[REQ_INSTR] = req[REQ_INSTR]
                       & (~req[REQ_DATA] | instrOverData)
                       & (~req[REQ_NODE] | instrOverNode);
        gnt[REQ_DATA]  = req[REQ_DATA]
                       & (~req[REQ_INSTR] | ~instrOverData)
                       & (~req[REQ_NODE]  | dataOverNode);
        gnt[REQ_NODE]  = req[REQ_NODE]
                       & (~req[REQ_INSTR] | ~instrOverNode)
                       & (~req[REQ_DATA]  | ~dataOverNode);
    end

    // Demote the winner below both others; the untouched pair keeps its bit,
    // which is what preserves the losers' relative order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrOverData <= 1'b1;
            instrOverNode <= 1'b1;
            dataOverNode  <= 1'b1;
        end else if (update) begin
            if (gnt[REQ_INSTR]) begin
                instrOverData <= 1'b0;
                instrOverNode <= 1'b0;
            end else if (gnt[REQ_DATA]) begin
                instrOverData <= 1'b1;
                dataOverNode  <= 1'b0;
            end else if (gnt[REQ_NODE]) begin
                instrOverNode <= 1'b1;
                dataOverNode  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_mem_arbiter.sv
// nn_mem_arbiter
// Shares the single port of the 2048 x 16 block memory between instruction
// fetch, data load/store and 16-word node-vector bursts.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : nn_mem_arbiter_if.slave -- requester handshakes (req/gnt/rvalid/rdata),
//         node burst outputs (node_idx, node_done) and the memory port (mem_*)
module nn_mem_arbiter
    import nn_mem_arb_pkg::*;
#(
    parameter int DATA_W    = MEM_DATA_W,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int BURST_LEN = NODE_BURST_LEN
) (
    input  logic               clk,
    input  logic               rst,
    nn_mem_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(BURST_LEN);

    arb_state_t        state;
    arb_state_t        stateNext;
    logic [CNT_W-1:0]  beatCnt;
    logic [CNT_W-1:0]  beatCntNext;
    logic [ADDR_W-1:0] burstBase;
    logic [ADDR_W-1:0] burstBaseNext;

    logic              portFree;
    logic              lastBeat;
    logic [2:0]        arbReq;
    logic [2:0]        arbGnt;

    logic              rvInstr;
    logic              rvData;
    logic              rvNode;
    logic [CNT_W-1:0]  rvIdx;
    logic              rvDone;

    // Grants are only possible in IDLE; rst is folded in so that every output
    // drops to zero the moment reset is asserted, even with requests pending.
    assign portFree = (state == ARB_IDLE) && rst;
    assign arbReq   = portFree ? {bus.node_req, bus.data_req, bus.instr_req} : 3'b000;
    assign lastBeat = (beatCnt == CNT_W'(BURST_LEN - 1));

    rr_arbiter3 uArbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (arbReq),
        .update (portFree),
        .gnt    (arbGnt)
    );

    assign bus.instr_gnt = arbGnt[REQ_INSTR];
    assign bus.data_gnt  = arbGnt[REQ_DATA];
    assign bus.node_gnt  = arbGnt[REQ_NODE];

    // Next-state and memory-port drive. A node grant issues beat 0 directly and
    // hands the remaining beats to BURST; the counter wraps to 0 after the last
    // beat so IDLE arbitration resumes immediately.
    always_comb begin
        stateNext     = state;
        beatCntNext   = beatCnt;
        burstBaseNext = burstBase;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            ARB_IDLE: begin
                if (arbGnt[REQ_INSTR]) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.instr_addr;
                end else if (arbGnt[REQ_DATA]) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.data_we;
                    bus.mem_addr  = bus.data_addr;
                    bus.mem_wdata = bus.data_wdata;
                end else if (arbGnt[REQ_NODE]) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_addr  = bus.node_addr;
                    stateNext     = ARB_BURST;
                    beatCntNext   = CNT_W'(1);
                    burstBaseNext = bus.node_addr;
                end
            end
            ARB_BURST: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = burstBase + ADDR_W'(beatCnt);
                beatCntNext  = beatCnt + CNT_W'(1);
                if (lastBeat) begin
                    stateNext = ARB_IDLE;
                end
            end
            default: begin
                stateNext = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            beatCnt   <= '0;
            burstBase <= '0;
        end else begin
            state     <= stateNext;
            beatCnt   <= beatCntNext;
            burstBase <= burstBaseNext;
        end
    end

    // Read-return pipeline: one flag per requester tracks who owns the word the
    // memory presents next cycle. Writes never return data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvInstr <= 1'b0;
            rvData  <= 1'b0;
            rvNode  <= 1'b0;
            rvIdx   <= '0;
            rvDone  <= 1'b0;
        end else begin
            rvInstr <= bus.instr_gnt;
            rvData  <= bus.data_gnt & ~bus.data_we;
            rvNode  <= bus.node_gnt | (state == ARB_BURST);
            rvIdx   <= (state == ARB_BURST) ? beatCnt : '0;
            rvDone  <= (state == ARB_BURST) && lastBeat;
        end
    end

    assign bus.instr_rvalid = rvInstr;
    assign bus.instr_rdata  = rvInstr ? bus.mem_rdata : '0;
    assign bus.data_rvalid  = rvData;
    assign bus.data_rdata   = rvData ? bus.mem_rdata : '0;
    assign bus.node_rvalid  = rvNode;
    assign bus.node_rdata   = rvNode ? bus.mem_rdata : '0;
    assign bus.node_idx     = rvIdx;
    assign bus.node_done    = rvDone;

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// tb_nn_mem_arbiter
// Directed bench for nn_mem_arbiter. A behavioural memory macro answers the
// memory port; a queue-based reference model predicts grants, memory traffic
// and read returns every cycle, and directed tests pin key timings to literals.
module tb_nn_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    nn_mem_arbiter_if bus ();

    nn_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro: registered read, one-cycle latency.
    logic [15:0] memArr [2048];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= memArr[bus.mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Reference model: priority is a list, the winner moves to the back.
    logic [15:0] refMem [2048];
    int          order[$];
    bit          bActive;
    int          bBase;
    int          bBeat;
    bit          pvI, pvD, pvN, pDone;
    int          pIdx;
    logic [15:0] pDI, pDD, pDN;

    // Monitor records used by the directed checks.
    int          nodeRvCount = 0;
    int          nodeDoneCount = 0;
    int          nodeDoneCyc = -1;
    int          nodeRvFirst = -1;
    bit          prevNodeRv = 1'b0;
    int          dataRvCount = 0;
    int          lastDataRvCyc = -1;
    logic [15:0] lastDataRdata = '0;
    logic [10:0] addrLog[$];
    logic [3:0]  idxLog[$];

    always @(negedge clk) begin
        logic [2:0]  reqVec;
        logic [2:0]  eG;
        bit          eEn, eWe, nvI, nvD, nvN, nDone;
        logic [10:0] eAddr;
        logic [15:0] eWd, nDI, nDD, nDN;
        int          win, pos, nIdx;
        if (!rst) begin
            order   = '{0, 1, 2};
            bActive = 1'b0;
            bBeat   = 0;
            bBase   = 0;
            {pvI, pvD, pvN, pDone} = 4'b0000;
            pIdx = 0;
            checkOutput("rstMemEn", 32'(bus.mem_en), 32'd0);
            checkOutput("rstGnt", 32'({bus.node_gnt, bus.data_gnt, bus.instr_gnt}), 32'd0);
            checkOutput("rstRvalid", 32'({bus.node_rvalid, bus.data_rvalid, bus.instr_rvalid}), 32'd0);
            checkOutput("rstDone", 32'(bus.node_done), 32'd0);
        end else begin
            reqVec = {bus.node_req, bus.data_req, bus.instr_req};
            eG = 3'b000; eEn = 1'b0; eWe = 1'b0; eAddr = '0; eWd = '0;
            nvI = 1'b0; nvD = 1'b0; nvN = 1'b0; nDone = 1'b0; nIdx = 0;
            nDI = '0; nDD = '0; nDN = '0;
            if (bActive) begin
                eEn   = 1'b1;
                eAddr = 11'((bBase + bBeat) % 2048);
                nvN   = 1'b1;
                nIdx  = bBeat;
                nDone = (bBeat == 15);
                nDN   = refMem[eAddr];
                bBeat++;
                if (bBeat == 16) bActive = 1'b0;
            end else begin
                win = -1;
                pos = 0;
                for (int k = 0; k < order.size(); k++) begin
                    if (win < 0 && reqVec[order[k]]) begin
                        win = order[k];
                        pos = k;
                    end
                end
                if (win >= 0) begin
                    eG[win] = 1'b1;
                    eEn     = 1'b1;
                    order.delete(pos);
                    order.push_back(win);
                    if (win == 0) begin
                        eAddr = bus.instr_addr;
                        nvI   = 1'b1;
                        nDI   = refMem[eAddr];
                    end else if (win == 1) begin
                        eAddr = bus.data_addr;
                        if (bus.data_we) begin
                            eWe = 1'b1;
                            eWd = bus.data_wdata;
                            refMem[eAddr] = bus.data_wdata;
                        end else begin
                            nvD = 1'b1;
                            nDD = refMem[eAddr];
                        end
                    end else begin
                        eAddr   = bus.node_addr;
                        bBase   = int'(bus.node_addr);
                        bBeat   = 1;
                        bActive = 1'b1;
                        nvN     = 1'b1;
                        nIdx    = 0;
                        nDN     = refMem[eAddr];
                    end
                end
            end
            checkOutput("instrGnt", 32'(bus.instr_gnt), 32'(eG[0]));
            checkOutput("dataGnt", 32'(bus.data_gnt), 32'(eG[1]));
            checkOutput("nodeGnt", 32'(bus.node_gnt), 32'(eG[2]));
            checkOutput("memEn", 32'(bus.mem_en), 32'(eEn));
            checkOutput("memWe", 32'(bus.mem_we), 32'(eWe));
            if (eEn) checkOutput("memAddr", 32'(bus.mem_addr), 32'(eAddr));
            if (eWe) checkOutput("memWdata", 32'(bus.mem_wdata), 32'(eWd));
            checkOutput("instrRvalid", 32'(bus.instr_rvalid), 32'(pvI));
            checkOutput("dataRvalid", 32'(bus.data_rvalid), 32'(pvD));
            checkOutput("nodeRvalid", 32'(bus.node_rvalid), 32'(pvN));
            checkOutput("nodeDone", 32'(bus.node_done), 32'(pDone));
            if (pvI) checkOutput("instrRdata", 32'(bus.instr_rdata), 32'(pDI));
            if (pvD) checkOutput("dataRdata", 32'(bus.data_rdata), 32'(pDD));
            if (pvN) begin
                checkOutput("nodeRdata", 32'(bus.node_rdata), 32'(pDN));
                checkOutput("nodeIdx", 32'(bus.node_idx), 32'(pIdx));
            end
            pvI = nvI; pvD = nvD; pvN = nvN; pDone = nDone;
            pIdx = nIdx; pDI = nDI; pDD = nDD; pDN = nDN;
        end
        if (bus.node_rvalid) begin
            nodeRvCount++;
            if (!prevNodeRv) nodeRvFirst = cyc;
            idxLog.push_back(bus.node_idx);
        end
        prevNodeRv = bus.node_rvalid;
        if (bus.node_done) begin
            nodeDoneCount++;
            nodeDoneCyc = cyc;
        end
        if (bus.data_rvalid) begin
            dataRvCount++;
            lastDataRvCyc = cyc;
            lastDataRdata = bus.data_rdata;
        end
        if (bus.mem_en) addrLog.push_back(bus.mem_addr);
    end

    // Requester behaviour: drop req after its grant unless told to hold it.
    int         gntCyc[3] = '{-1, -1, -1};
    int         gntCnt[3] = '{0, 0, 0};
    logic [2:0] lastReq = '0;
    logic [2:0] lastGnt = '0;
    bit         holdInstr = 1'b0;
    bit         reraiseData = 1'b0;

    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            bit dI, dD, dN;
            @(negedge clk);
            lastReq = {bus.node_req, bus.data_req, bus.instr_req};
            lastGnt = {bus.node_gnt, bus.data_gnt, bus.instr_gnt};
            dI = 1'b0; dD = 1'b0; dN = 1'b0;
            if (bus.instr_gnt) begin gntCyc[0] = cyc; gntCnt[0]++; dI = !holdInstr; end
            if (bus.data_gnt)  begin gntCyc[1] = cyc; gntCnt[1]++; dD = 1'b1; end
            if (bus.node_gnt)  begin gntCyc[2] = cyc; gntCnt[2]++; dN = 1'b1; end
            @(posedge clk);
            #1;
            if (dI) bus.instr_req = 1'b0;
            if (dD) bus.data_req = 1'b0;
            else if (reraiseData && !bus.data_req) bus.data_req = 1'b1;
            if (dN) bus.node_req = 1'b0;
        end
    endtask

    task automatic applyUntilGrant(input int id, input int budget);
        int startCnt;
        bit got;
        startCnt = gntCnt[id];
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            applyStimulus(1);
            got = (gntCnt[id] != startCnt);
        end
        checkOutput("grantWithinBudget", 32'(got), 32'd1);
    endtask

    initial begin
        int t0, snapRv, snapDone, v0, gI0, gD0;
        int iWait, dWait, maxI, maxD;
        for (int a = 0; a < 2048; a++) begin
            memArr[a] = '0;
            refMem[a] = '0;
        end
        bus.instr_req = 1'b0; bus.instr_addr = '0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;
        bus.node_req = 1'b0; bus.node_addr = '0;
        bus.mem_rdata = '0;
        rst = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetMemEn", 32'(bus.mem_en), 32'd0);
        checkOutput("resetNodeIdx", 32'(bus.node_idx), 32'd0);
        checkOutput("resetNodeRvalid", 32'(bus.node_rvalid), 32'd0);
        rst = 1'b1;
        applyStimulus(2);

        // All three request together: instr, data, node in consecutive cycles.
        $display("[TB] simultaneous requests");
        bus.instr_req = 1'b1; bus.instr_addr = 11'h010;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 11'h020;
        bus.node_req = 1'b1; bus.node_addr = 11'h100;
        t0 = cyc;
        snapRv = nodeRvCount;
        applyStimulus(22);
        checkOutput("simInstrGnt", 32'(gntCyc[0] - t0), 32'd0);
        checkOutput("simDataGnt", 32'(gntCyc[1] - t0), 32'd1);
        checkOutput("simNodeGnt", 32'(gntCyc[2] - t0), 32'd2);
        checkOutput("simFirstNodeRv", 32'(nodeRvFirst - t0), 32'd3);
        checkOutput("simNodeDone", 32'(nodeDoneCyc - t0), 32'd18);
        checkOutput("simNodeRvCount", 32'(nodeRvCount - snapRv), 32'd16);

        // Write then read back through the data port.
        $display("[TB] data write/read");
        v0 = dataRvCount;
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 11'h005; bus.data_wdata = 16'hBEEF;
        applyUntilGrant(1, 5);
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_wdata = 16'h0000;
        applyUntilGrant(1, 5);
        applyStimulus(2);
        checkOutput("rdRvCount", 32'(dataRvCount - v0), 32'd1);
        checkOutput("rdLatency", 32'(lastDataRvCyc - gntCyc[1]), 32'd1);
        checkOutput("rdData", 32'(lastDataRdata), 32'hBEEF);

        // Burst that wraps past the top of memory; base change after grant ignored.
        $display("[TB] wrapping burst");
        addrLog.delete();
        idxLog.delete();
        bus.node_req = 1'b1; bus.node_addr = 11'h7F8;
        applyUntilGrant(2, 5);
        bus.node_addr = 11'h123;
        applyStimulus(18);
        checkOutput("wrapAddrCount", 32'(addrLog.size()), 32'd16);
        checkOutput("wrapIdxCount", 32'(idxLog.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < addrLog.size()) checkOutput("wrapAddr", 32'(addrLog[i]), 32'((11'h7F8 + i) & 11'h7FF));
            if (i < idxLog.size()) checkOutput("wrapIdx", 32'(idxLog[i]), 32'(i));
        end

        // Instr held, data toggling: the two alternate.
        $display("[TB] instr held, data toggling");
        holdInstr = 1'b1; reraiseData = 1'b1;
        bus.instr_req = 1'b1; bus.instr_addr = 11'h011;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 11'h005;
        gI0 = gntCnt[0]; gD0 = gntCnt[1];
        iWait = 0; dWait = 0; maxI = 0; maxD = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1);
            if (lastReq[0] && !lastGnt[0]) iWait++; else iWait = 0;
            if (lastReq[1] && !lastGnt[1]) dWait++; else dWait = 0;
            if (iWait > maxI) maxI = iWait;
            if (dWait > maxD) maxD = dWait;
        end
        holdInstr = 1'b0; reraiseData = 1'b0;
        bus.instr_req = 1'b0; bus.data_req = 1'b0;
        checkOutput("altInstrWait", 32'(maxI <= 1), 32'd1);
        checkOutput("altDataWait", 32'(maxD <= 1), 32'd1);
        checkOutput("altInstrGnts", 32'(gntCnt[0] - gI0), 32'd6);
        checkOutput("altDataGnts", 32'(gntCnt[1] - gD0), 32'd6);
        applyStimulus(2);

        // Instr request raised right after a node grant waits out the burst.
        $display("[TB] request during burst");
        bus.node_req = 1'b1; bus.node_addr = 11'h040;
        applyUntilGrant(2, 5);
        bus.instr_req = 1'b1; bus.instr_addr = 11'h033;
        applyUntilGrant(0, 30);
        checkOutput("burstBlocksInstr", 32'(gntCyc[0] - gntCyc[2]), 32'd16);
        applyStimulus(2);

        // Reset asserted while beat 7 is being issued.
        $display("[TB] reset mid-burst");
        bus.node_req = 1'b1; bus.node_addr = 11'h200;
        applyUntilGrant(2, 5);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midRstNodeRvalid", 32'(bus.node_rvalid), 32'd0);
        checkOutput("midRstNodeIdx", 32'(bus.node_idx), 32'd0);
        checkOutput("midRstMemEn", 32'(bus.mem_en), 32'd0);
        checkOutput("midRstMemAddr", 32'(bus.mem_addr), 32'd0);
        snapRv = nodeRvCount;
        snapDone = nodeDoneCount;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(20);
        checkOutput("postRstNodeRv", 32'(nodeRvCount - snapRv), 32'd0);
        checkOutput("postRstNodeDone", 32'(nodeDoneCount - snapDone), 32'd0);
        bus.instr_req = 1'b1; bus.instr_addr = 11'h001;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 11'h002;
        bus.node_req = 1'b1; bus.node_addr = 11'h300;
        t0 = cyc;
        applyStimulus(22);
        checkOutput("postRstInstrGnt", 32'(gntCyc[0] - t0), 32'd0);
        checkOutput("postRstDataGnt", 32'(gntCyc[1] - t0), 32'd1);
        checkOutput("postRstNodeGnt", 32'(gntCyc[2] - t0), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
